// File: rtl/pipeline_8bit_subtractor_if.sv
// Operand/result bus with valid/ready handshake on both sides of the subtractor.
// master: the side that supplies operands and consumes results.
// slave:  the subtractor itself.
interface pipeline_8bit_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, bin, in_valid, out_ready,
        input  in_ready, diff, bout, ovf, zero, out_valid
    );

    modport slave (
        input  a, b, bin, in_valid, out_ready,
        output in_ready, diff, bout, ovf, zero, out_valid
    );
endinterface

// File: rtl/pipeline_8bit_subtractor.sv
// Two-stage pipelined subtractor: diff = a - b - bin (mod 2^WIDTH).
// Stage 1 subtracts the low LOW_W bits and keeps the borrow; stage 2 finishes
// the high slice using only that borrow, and produces bout, ovf and zero.
// Each stage is a skid-free register slice with valid/ready, giving full
// throughput and a two-cycle latency from input accept to out_valid.
module pipeline_8bit_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LOW_W = 4
) (
    input logic                       enable,
    input logic                       rst,
    pipeline_8bit_subtractor_if.slave bus
);
    localparam int unsigned HI_W = WIDTH - LOW_W;

    // Stage 1 registers
    logic              s1_valid_q, s1_valid_d;
    logic [LOW_W-1:0]  lo_q,       lo_d;
    logic              b1_q,       b1_d;
    logic [HI_W-1:0]   a_hi_q,     a_hi_d;
    logic [HI_W-1:0]   b_hi_q,     b_hi_d;
    logic              a_msb_q,    a_msb_d;
    logic              b_msb_q,    b_msb_d;

    // Stage 2 registers (drive the outputs directly)
    logic              s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  diff_q,     diff_d;
    logic              bout_q,     bout_d;
    logic              ovf_q,      ovf_d;
    logic              zero_q,     zero_d;

    // Combinational helpers
    logic              s1_ready;
    logic              s2_ready;
    logic [LOW_W:0]    lo_sub;
    logic [HI_W:0]     hi_sub;
    logic [WIDTH-1:0]  diff_new;

    // Backpressure: a stage may load when it is empty or its contents move on.
    always_comb begin
        s2_ready = !s2_valid_q || bus.out_ready;
        s1_ready = !s1_valid_q || s2_ready;
    end

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    // Stage 1 next state: low-slice subtract, capture high slices and sign bits.
    always_comb begin
        lo_sub     = {1'b0, bus.a[LOW_W-1:0]} - {1'b0, bus.b[LOW_W-1:0]}
                   - {{LOW_W{1'b0}}, bus.bin};
        s1_valid_d = s1_valid_q;
        lo_d       = lo_q;
        b1_d       = b1_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        if (s1_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                lo_d    = lo_sub[LOW_W-1:0];
                b1_d    = lo_sub[LOW_W];
                a_hi_d  = bus.a[WIDTH-1:LOW_W];
                b_hi_d  = bus.b[WIDTH-1:LOW_W];
                a_msb_d = bus.a[WIDTH-1];
                b_msb_d = bus.b[WIDTH-1];
            end
        end
    end

    // Stage 2 next state: high-slice subtract with the stage-1 borrow, flags.
    always_comb begin
        hi_sub     = {1'b0, a_hi_q} - {1'b0, b_hi_q} - {{HI_W{1'b0}}, b1_q};
        diff_new   = {hi_sub[HI_W-1:0], lo_q};
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = diff_new;
                bout_d = hi_sub[HI_W];
                ovf_d  = (a_msb_q != b_msb_q) && (diff_new[WIDTH-1] != a_msb_q);
                zero_d = (diff_new == '0);
            end
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge enable or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            lo_q       <= '0;
            b1_q       <= 1'b0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            lo_q       <= lo_d;
            b1_q       <= b1_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end
endmodule

// File: tb/tb_pipeline_8bit_subtractor.sv
// Testbench for pipeline_8bit_subtractor: directed vectors, back-to-back
// streaming, backpressure, random traffic and mid-stream reset, all checked
// against an arithmetic reference model and an in-order expectation queue.
module tb_pipeline_8bit_subtractor;
    logic enable = 1'b0;
    logic rst    = 1'b1;

    pipeline_8bit_subtractor_if #(.WIDTH(8)) bus ();

    pipeline_8bit_subtractor #(.WIDTH(8), .LOW_W(4)) dut (
        .enable (enable),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 enable = ~enable;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        logic       zero;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full operands.
    function automatic exp_t ref_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t e;
        int   u;
        int   s;
        u      = int'(a) - int'(b) - int'(bin);
        s      = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.diff = u[7:0];
        e.bout = (u < 0);
        e.ovf  = (s < -128) || (s > 127);
        e.zero = (u[7:0] == 8'h00);
        e.acc  = 0;
        return e;
    endfunction

    // One clock cycle: drive, check outputs against the model, advance.
    task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ibin, input logic ordy, output logic took);
        logic exp_v;
        logic exp_rdy;
        logic ofire;
        exp_t e;
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.bin       = ibin;
        bus.out_ready = ordy;
        #2;
        exp_v   = (q.size() > 0) && (cyc >= q[0].acc + 2);
        exp_rdy = !((q.size() >= 2) && !ordy);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) begin
            chk("diff", 32'(bus.diff), 32'(q[0].diff));
            chk("bout", 32'(bus.bout), 32'(q[0].bout));
            chk("ovf",  32'(bus.ovf),  32'(q[0].ovf));
            chk("zero", 32'(bus.zero), 32'(q[0].zero));
        end
        took  = iv && bus.in_ready;
        ofire = exp_v && ordy;
        @(posedge enable);
        #1;
        if (ofire) void'(q.pop_front());
        if (took) begin
            e     = ref_op(ia, ib, ibin);
            e.acc = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       took;
        logic [7:0] pa, pb;
        logic       pbin;
        logic       pv;
        int         sent;
        logic [7:0] va [7];
        logic [7:0] vb [7];
        logic       vc [7];

        va = '{8'h50, 8'h30, 8'h10, 8'h80, 8'h7F, 8'h05, 8'h00};
        vb = '{8'h30, 8'h50, 8'h01, 8'h01, 8'hFF, 8'h04, 8'h00};
        vc = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff",      32'(bus.diff),      32'd0);
        chk("rst_bout",      32'(bus.bout),      32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        chk("rst_zero",      32'(bus.zero),      32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge enable);
        #1;
        rst = 1'b0;

        // Directed vectors, single op then back-to-back
        step(1'b1, va[0], vb[0], vc[0], 1'b1, took);
        chk("accept_first", 32'(took), 32'd1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took);
        for (int i = 1; i < 7; i++) step(1'b1, va[i], vb[i], vc[i], 1'b1, took);
        repeat (3) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took);
        chk("directed_drained", 32'(q.size()), 32'd0);

        // Six back-to-back random ops with free-flowing output
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, took);
            chk("stream_accept", 32'(took), 32'd1);
        end

        // Stall output 4 cycles while the source keeps offering, then release
        pv = 1'b0; pa = '0; pb = '0; pbin = 1'b0; sent = 0;
        for (int i = 0; i < 16; i++) begin
            if (!pv && sent < 6) begin
                pa = 8'($urandom); pb = 8'($urandom); pbin = 1'($urandom); pv = 1'b1;
            end
            step(pv, pa, pb, pbin, (i >= 4), took);
            if (took) begin
                pv = 1'b0;
                sent++;
            end
        end
        chk("stall_all_sent", 32'(sent), 32'd6);
        chk("stall_drained",  32'(q.size()), 32'd0);

        // Random traffic with random backpressure; source holds until accepted
        pv = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!pv && ($urandom_range(3) != 0)) begin
                pa = 8'($urandom); pb = 8'($urandom); pbin = 1'($urandom); pv = 1'b1;
            end
            step(pv, pa, pb, pbin, 1'($urandom_range(3) != 0), took);
            if (took) pv = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            step(pv, pa, pb, pbin, 1'b1, took);
            if (took) pv = 1'b0;
        end
        chk("random_drained", 32'(q.size()), 32'd0);

        // Mid-stream reset with two ops in flight
        step(1'b1, 8'h12, 8'h34, 1'b0, 1'b1, took);
        step(1'b1, 8'h56, 8'h07, 1'b1, 1'b1, took);
        chk("inflight_before_rst", 32'(q.size()), 32'd2);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_diff",      32'(bus.diff),      32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        q.delete();
        @(posedge enable);
        #1;
        rst = 1'b0;
        cyc++;
        repeat (3) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took);
        step(1'b1, 8'hA5, 8'h5A, 1'b0, 1'b1, took);
        repeat (3) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took);
        chk("post_rst_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
